// File: rtl/rv32i_instr_encoder.sv
// RV32I field-level instruction encoder with output FIFO and address stream.
// Packs class/funct/register/immediate fields into 32-bit RV32I words and
// range-checks the immediate first. Rejected requests raise err_pulse_o and
// bump err_cnt_o. Legal words are queued with their word address.
// Optional feature macro: RV32I_ENC_HALT_ON_ERR_EN. When it is defined, the
// first rejected request halts intake until clr_i.
module rv32i_instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        in_class_i,
    input  logic [2:0]        in_funct3_i,
    input  logic              in_alt_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  logic [31:0]       in_imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              err_pulse_o,
    output logic [7:0]        err_cnt_o,
    output logic              halted_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]       mem_instr_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_q  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_pulse_q, err_pulse_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              run;
    logic              legal;
    logic [31:0]       enc;
    logic              accept, push, pop, err;
    logic signed [31:0] imm_s;
    logic              imm12_ok;

    assign imm_s    = in_imm_i;
    assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);

    // Field packing and legality check for the offered request.
    always_comb begin
        legal = 1'b0;
        enc   = '0;
        case (in_class_i)
            4'd0: begin
                legal = 1'b1;
                enc = {1'b0, in_alt_i, 5'b0, in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, 7'h33};
            end
            4'd1: begin
                if (in_funct3_i == 3'b001 || in_funct3_i == 3'b101) begin
                    legal = (imm_s >= 32'sd0) && (imm_s <= 32'sd31);
                    enc = {1'b0, in_alt_i, 5'b0, in_imm_i[4:0], in_rs1_i, in_funct3_i, in_rd_i, 7'h13};
                end else begin
                    legal = imm12_ok;
                    enc = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'h13};
                end
            end
            4'd2: begin
                legal = imm12_ok;
                enc = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'h03};
            end
            4'd3: begin
                legal = imm12_ok;
                enc = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i, in_imm_i[4:0], 7'h23};
            end
            4'd4: begin
                legal = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm_i[0];
                enc = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, in_funct3_i,
                       in_imm_i[4:1], in_imm_i[11], 7'h63};
            end
            4'd5: begin
                legal = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm_i[0];
                enc = {in_imm_i[20], in_imm_i[10:1], in_imm_i[11], in_imm_i[19:12], in_rd_i, 7'h6F};
            end
            4'd6: begin
                legal = imm12_ok;
                enc = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'h67};
            end
            4'd7: begin
                legal = (in_imm_i[11:0] == 12'h000);
                enc = {in_imm_i[31:12], in_rd_i, 7'h37};
            end
            4'd8: begin
                legal = (in_imm_i[11:0] == 12'h000);
                enc = {in_imm_i[31:12], in_rd_i, 7'h17};
            end
            4'd9: begin
                legal = imm12_ok;
                enc = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, 7'h73};
            end
            default: begin
                legal = 1'b0;
                enc   = '0;
            end
        endcase
    end

    // clr_i discards both sides' transfers in the cycle it is asserted.
    assign in_ready_o  = (count_q != FULL_CNT) && run;
    assign out_valid_o = (count_q != '0);
    assign accept      = in_valid_i && in_ready_o && !clr_i;
    assign push        = accept && legal;
    assign err         = accept && !legal;
    assign pop         = out_valid_o && out_ready_i && !clr_i;

    // When empty, the address output shows the next address to be issued.
    assign out_instr_o = out_valid_o ? mem_instr_q[rd_ptr_q] : '0;
    assign out_addr_o  = out_valid_o ? mem_addr_q[rd_ptr_q] : addr_q;
    assign err_pulse_o = err_pulse_q;
    assign err_cnt_o   = err_cnt_q;

`ifdef RV32I_ENC_HALT_ON_ERR_EN
    // state  | meaning
    // S_RUN  | accepting requests
    // S_HALT | a request was rejected; intake stopped, FIFO still drains
    typedef enum logic {S_RUN, S_HALT} state_t;
    state_t state_q, state_d;

    // Halt state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // Next state: any rejection halts, only clr_i resumes.
    always_comb begin
        state_d = state_q;
        if (clr_i)    state_d = S_RUN;
        else if (err) state_d = S_HALT;
    end

    assign run      = (state_q == S_RUN);
    assign halted_o = (state_q == S_HALT);
`else
    assign run      = 1'b1;
    assign halted_o = 1'b0;
`endif

    // Next-state for FIFO pointers, occupancy, address counter and error stats.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        err_pulse_d = err;
        err_cnt_d   = err_cnt_q;
        if (clr_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            addr_d      = BASE_ADDR;
            err_pulse_d = 1'b0;
            err_cnt_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                addr_d   = addr_q + ADDR_W'(4);
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Control register update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= BASE_ADDR;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // FIFO storage; contents are only visible while occupied, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= enc;
            mem_addr_q[wr_ptr_q]  <= addr_q;
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed bench for rv32i_instr_encoder (default build, halt feature off).
module tb_rv32i_instr_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clr_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [3:0]  in_class_i = '0;
    logic [2:0]  in_funct3_i = '0;
    logic        in_alt_i = 1'b0;
    logic [4:0]  in_rd_i = '0, in_rs1_i = '0, in_rs2_i = '0;
    logic [31:0] in_imm_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        err_pulse_o;
    logic [7:0]  err_cnt_o;
    logic        halted_o;

    int n_checks = 0;
    int n_pass   = 0;

    rv32i_instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_class_i(in_class_i), .in_funct3_i(in_funct3_i), .in_alt_i(in_alt_i),
        .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_imm_i(in_imm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_instr_o(out_instr_o), .out_addr_o(out_addr_o),
        .err_pulse_o(err_pulse_o), .err_cnt_o(err_cnt_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // Offer one request and return 1 ns after the edge that accepted it.
    task automatic send(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        logic got;
        got = 1'b0;
        in_class_i = cls; in_funct3_i = f3; in_alt_i = alt;
        in_rd_i = rd; in_rs1_i = rs1; in_rs2_i = rs2; in_imm_i = imm;
        in_valid_i = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                @(posedge clk_i);
                #1 got = 1'b1;
            end
        end
        in_valid_i = 1'b0;
        check("accept", {31'b0, got}, 32'd1);
    endtask

    // Offer an illegal request and check the rejection side effects.
    task automatic send_bad(input string tag, input logic [3:0] cls, input logic [2:0] f3,
                            input logic [31:0] imm, input logic [7:0] exp_cnt);
        send(cls, f3, 1'b0, 5'd1, 5'd1, 5'd2, imm);
        check({tag, "_err_pulse"}, {31'b0, err_pulse_o}, 32'd1);
        check({tag, "_no_word"}, {31'b0, out_valid_o}, 32'd0);
        check({tag, "_err_cnt"}, {24'b0, err_cnt_o}, {24'b0, exp_cnt});
    endtask

    // Wait for a word at the FIFO head, check it, then consume it.
    task automatic expect_word(input string tag, input logic [31:0] instr, input logic [31:0] addr);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk_i);
            if (out_valid_o) got = 1'b1;
        end
        check({tag, "_valid"}, {31'b0, got}, 32'd1);
        if (got) begin
            check({tag, "_instr"}, out_instr_o, instr);
            check({tag, "_addr"}, out_addr_o, addr);
            out_ready_i = 1'b1;
            @(posedge clk_i);
            #1 out_ready_i = 1'b0;
        end
    endtask

    logic [31:0] fill_instr [5];
    logic [4:0]  fill_rd    [5];

    initial begin
        fill_instr[0] = 32'h00100093; fill_instr[1] = 32'h00200113;
        fill_instr[2] = 32'h00300193; fill_instr[3] = 32'h00400213;
        fill_instr[4] = 32'h00500293;
        for (int k = 0; k < 5; k++) fill_rd[k] = 5'(k + 1);

        // Reset values while rst_i is held.
        #2;
        check("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_out_instr", out_instr_o, 32'h0);
        check("rst_out_addr", out_addr_o, 32'h0);
        check("rst_err_pulse", {31'b0, err_pulse_o}, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt_o}, 32'd0);
        check("rst_halted", {31'b0, halted_o}, 32'd0);
        do_reset();

        // addi x1, x0, 5 -- visible right after the accepting edge.
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        check("addi_latency", {31'b0, out_valid_o}, 32'd1);
        expect_word("addi", 32'h00500093, 32'h0);

        // add / sub x3, x1, x2
        do_reset();
        send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word("add", 32'h002081B3, 32'h0);
        send(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word("sub", 32'h402081B3, 32'h4);

        // Rejections do not consume addresses.
        do_reset();
        send_bad("i_2048", 4'd1, 3'd0, 32'd2048, 8'd1);
        send_bad("lui_low", 4'd7, 3'd0, 32'd1, 8'd2);
        @(posedge clk_i); #1;
        check("err_pulse_one_cycle", {31'b0, err_pulse_o}, 32'd0);
        check("halted_default", {31'b0, halted_o}, 32'd0);
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_word("after_err", 32'h00500093, 32'h0);

        // Encodings and immediate boundaries.
        send(4'd1, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3);
        expect_word("srai", 32'h4030D093, 32'h4);
        send(4'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC);
        expect_word("sw_neg", 32'hFE312E23, 32'h8);
        send(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1048574);
        expect_word("jal_max", 32'h7FFFF0EF, 32'hC);
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);
        expect_word("addi_min", 32'h80000093, 32'h10);
        send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        expect_word("beq", 32'h00208463, 32'h14);
        send(4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        expect_word("lui", 32'h123452B7, 32'h18);
        send_bad("slli_32", 4'd1, 3'd1, 32'd32, 8'd3);
        send_bad("class_10", 4'd10, 3'd0, 32'd0, 8'd4);
        send_bad("beq_odd", 4'd4, 3'd0, 32'd7, 8'd5);
        send_bad("jal_odd", 4'd5, 3'd0, 32'd3, 8'd6);
        send_bad("beq_4096", 4'd4, 3'd0, 32'd4096, 8'd7);
        send(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00001000);
        expect_word("auipc", 32'h00001097, 32'h1C);

        // Fill the FIFO, then drain while a fifth request waits.
        do_reset();
        for (int k = 0; k < 4; k++) send(4'd1, 3'd0, 1'b0, fill_rd[k], 5'd0, 5'd0, {27'b0, fill_rd[k]});
        @(negedge clk_i);
        check("full_in_ready", {31'b0, in_ready_o}, 32'd0);
        check("full_out_valid", {31'b0, out_valid_o}, 32'd1);
        fork
            send(4'd1, 3'd0, 1'b0, fill_rd[4], 5'd0, 5'd0, 32'd5);
            for (int k = 0; k < 5; k++) expect_word("drain", fill_instr[k], 32'(k * 4));
        join

        // clr_i with words queued and a same-cycle request.
        do_reset();
        send_bad("pre_clr", 4'd1, 3'd0, 32'd4096, 8'd1);
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
        in_class_i = 4'd1; in_funct3_i = 3'd0; in_rd_i = 5'd1; in_imm_i = 32'd5;
        in_valid_i = 1'b1; out_ready_i = 1'b1; clr_i = 1'b1;
        @(posedge clk_i);
        #1 clr_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        check("clr_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("clr_err_cnt", {24'b0, err_cnt_o}, 32'd0);
        check("clr_out_addr", out_addr_o, 32'h0);
        send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word("after_clr", 32'h002081B3, 32'h0);

        // Asynchronous reset mid-stream.
        send_bad("pre_rst", 4'd9, 3'd0, 32'd4096, 8'd1);
        send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("arst_in_ready", {31'b0, in_ready_o}, 32'd1);
        check("arst_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("arst_out_instr", out_instr_o, 32'h0);
        check("arst_out_addr", out_addr_o, 32'h0);
        check("arst_err_pulse", {31'b0, err_pulse_o}, 32'd0);
        check("arst_err_cnt", {24'b0, err_cnt_o}, 32'd0);
        check("arst_halted", {31'b0, halted_o}, 32'd0);
        out_ready_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
